mem_access_unit: RTL and testbench

- MEM-stage load/store initiator, sitting between the pipeline and the word-addressed data memory.
- Accepts one typed load/store op (LW/LH/LHU/LB/LBU/SW/SH/SB) and checks alignment.
- Issues a word-aligned request with byte enables and lane-replicated write data over a req/ack handshake.
- Stalls the pipeline while the request is outstanding, then returns sign/zero-extended load data with a one-cycle done pulse.

---
 rtl/mem_op_pkg.sv | 44 ++++
 rtl/mem_access_unit_load_extender.sv | 38 +++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_op_pkg.sv
// Shared encodings and decode helpers for the MEM-stage load/store unit.
package mem_op_pkg;

    // Operation encodings as presented on op_type by the pipeline.
    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } opType_t;

    // Access sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } fsmState_t;

    // Stores write memory; everything else is a load.
    function automatic logic is_store(input opType_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Ops wider than a byte need at least halfword alignment.
    function automatic logic is_half_or_word(input opType_t op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_SW) || (op == OP_SH);
    endfunction

    // Full-word ops additionally need addr[1] clear.
    function automatic logic isWord(input opType_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // An op is misaligned when its natural size does not divide the address.
    function automatic logic isMisaligned(input opType_t op, input logic [1:0] offset);
        return (is_half_or_word(op) && offset[0]) || (isWord(op) && offset[1]);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Picks the addressed byte/halfword out of a read word and extends it to 32 bits.
module load_extender
    import mem_op_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  op_type,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    opType_t     opDec;

    assign opDec = opType_t'(op_type);

    // Lane selection and sign/zero extension; purely combinational.
    // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        byteSel   = mem_rdata[7:0];
        halfSel   = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        rdata_ext = mem_rdata;
        case (offset)
            2'd0:    byteSel = mem_rdata[7:0];
            2'd1:    byteSel = mem_rdata[15:8];
            2'd2:    byteSel = mem_rdata[23:16];
            default: byteSel = mem_rdata[31:24];
        endcase
        case (opDec)
            OP_LB:   rdata_ext = {{24{byteSel[7]}}, byteSel};
            OP_LBU:  rdata_ext = {24'd0, byteSel};
            OP_LH:   rdata_ext = {{16{halfSel[15]}}, halfSel};
            OP_LHU:  rdata_ext = {16'd0, halfSel};
            default: rdata_ext = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: alignment check, word request with byte
// enables over req/ack, pipeline stall, extended load result and timeout.
module mem_access_unit
    import mem_op_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_exc,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Last wait-counter value before the request is declared dead.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    fsmState_t         state;
    fsmState_t         nextState;
    logic [WAIT_W-1:0] waitCnt;
    opType_t           reqOp;
    opType_t           opLatched;
    logic [1:0]        offsetLatched;
    logic              misaligned;
    logic              accept;
    logic              waitExpired;
    logic [3:0]        laneBe;
    logic [31:0]       laneData;
    logic [31:0]       rdataExt;

    assign reqOp       = opType_t'(op_type);
    assign misaligned  = isMisaligned(reqOp, addr[1:0]);
    assign accept      = (state == S_IDLE) && op_valid && !misaligned;
    assign waitExpired = (state == S_REQ) && !mem_ack && (waitCnt == WAIT_LAST);

    // Byte enables and lane-replicated store data for the incoming op.
    always_comb begin
        laneBe   = 4'b1111;
        laneData = wdata;
        case (reqOp)
            OP_SH: begin
                laneBe   = addr[1] ? 4'b1100 : 4'b0011;
                laneData = {2{wdata[15:0]}};
            end
            OP_SB: begin
                laneBe   = 4'b0001 << addr[1:0];
                laneData = {4{wdata[7:0]}};
            end
            default: begin
                laneBe   = 4'b1111;
                laneData = wdata;
            end
        endcase
    end

    // Next-state logic plus the state-decoded outputs (stall, request, done).
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        mem_req   = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = accept;
                if (accept) begin
                    nextState = S_REQ;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    nextState = S_DONE;
                end else if (waitCnt == WAIT_LAST) begin
                    nextState = S_IDLE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                nextState = S_IDLE;
            end
            default: nextState = S_IDLE;
        endcase
    end

    // State register and wait counter; the counter only runs while a request stays pending.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            waitCnt <= '0;
        end else begin
            state <= nextState;
            if ((state == S_REQ) && (nextState == S_REQ)) begin
                waitCnt <= waitCnt + 1'b1;
            end else begin
                waitCnt <= '0;
            end
        end
    end

    // One-cycle exception pulses: misalignment on a refused op, timeout on a dead request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_exc <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            addr_exc <= (state == S_IDLE) && op_valid && misaligned;
            bus_err  <= waitExpired;
        end
    end

    // Capture the accepted op; the request fields stay frozen until the next accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_pc        <= '0;
            opLatched     <= OP_LW;
            offsetLatched <= '0;
        end else if (accept) begin
            mem_addr      <= {addr[31:2], 2'b00};
            mem_be        <= laneBe;
            mem_wdata     <= laneData;
            mem_we        <= is_store(reqOp);
            mem_pc        <= pc;
            opLatched     <= reqOp;
            offsetLatched <= addr[1:0];
        end
    end

    load_extender u_load_extender (
        .mem_rdata (mem_rdata),
        .offset    (offsetLatched),
        .op_type   (opLatched),
        .rdata_ext (rdataExt)
    );

    // Latch the result on ack so it is presented during the done cycle; stores report zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if ((state == S_REQ) && mem_ack) begin
            rdata <= is_store(opLatched) ? 32'd0 : rdataExt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expectations from a
// size/offset arithmetic model, responder plays the memory, monitor compares.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 4;
    localparam int NEVER    = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_type = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        busy, done, addr_exc, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_pc;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
        .addr(addr), .wdata(wdata), .pc(pc), .busy(busy), .done(done),
        .rdata(rdata), .addr_exc(addr_exc), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] pc;
        int          reqCycles;   // -1: request is abandoned, length not checked
    } reqItem_t;

    typedef struct {
        logic [2:0]  kind;        // {done, bus_err, addr_exc}
        int          cycle;
        logic [31:0] rdata;
    } evtItem_t;

    typedef struct {
        int          delay;
        logic [31:0] word;
    } respItem_t;

    reqItem_t  reqQ[$];
    evtItem_t  evtQ[$];
    respItem_t respQ[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int evtSeen = 0;
    int evtBase = 0;
    bit holdAck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int opSize(input int op);
        case (op)
            0, 5:    return 4;
            1, 2, 6: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit opStore(input int op);
        return op >= 5;
    endfunction

    function automatic logic [31:0] modelLoad(input int op, input logic [31:0] a, input logic [31:0] word);
        int     sz   = opSize(op);
        int     sh   = 8 * int'(a[1:0]);
        longint full = longint'(1) << (8 * sz);
        longint v    = longint'(word >> sh) % full;
        if ((op == 1 || op == 3) && v >= full / 2) v = v - full;
        return 32'(v);
    endfunction

    function automatic logic [3:0] modelBe(input int op, input logic [31:0] a);
        int m;
        if (!opStore(op)) return 4'b1111;
        m = ((1 << opSize(op)) - 1) << int'(a[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] modelData(input int op, input logic [31:0] wd);
        logic [31:0] d;
        int sz = opSize(op);
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % sz) +: 8];
        return d;
    endfunction

    // ---------------- cycle counter ----------------
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory responder ----------------
    respItem_t curResp;
    bit        respActive = 1'b0;
    int        respCnt = 0;

    always @(negedge clk) begin
        #1;
        if (mem_req) begin
            if (!respActive) begin
                respActive = 1'b1;
                respCnt = 0;
                if (respQ.size() > 0) curResp = respQ.pop_front();
                else begin curResp.delay = NEVER; curResp.word = 32'd0; end
            end
            if (respCnt == curResp.delay) begin
                mem_ack = 1'b1;
                mem_rdata = curResp.word;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end
            respCnt++;
        end else begin
            respActive = 1'b0;
            mem_ack = holdAck | ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
    end

    // ---------------- monitor ----------------
    reqItem_t curReq;
    bit       reqActive = 1'b0;
    bit       prevReq = 1'b0;
    int       reqCount = 0;
    evtItem_t curEvt;

    always @(negedge clk) begin
        if (mem_req) begin
            if (!prevReq) begin
                if (reqQ.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_req: got mem_req=1 expected no request (cycle %0d)", cyc);
                    reqActive = 1'b0;
                end else begin
                    curReq = reqQ.pop_front();
                    reqActive = 1'b1;
                    reqCount = 0;
                end
            end
            if (reqActive) begin
                check("mem_addr", mem_addr, curReq.addr);
                check("mem_be", 32'(mem_be), 32'(curReq.be));
                check("mem_we", 32'(mem_we), 32'(curReq.we));
                check("mem_pc", mem_pc, curReq.pc);
                if (curReq.we) check("mem_wdata", mem_wdata, curReq.wdata);
            end
            check("busy_req", 32'(busy), 32'd1);
            reqCount++;
        end else if (prevReq && reqActive) begin
            if (curReq.reqCycles >= 0) check("req_cycles", reqCount, curReq.reqCycles);
            reqActive = 1'b0;
        end
        prevReq = mem_req;

        if (done || bus_err || addr_exc) begin
            evtSeen++;
            if (evtQ.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_event: got {done,bus_err,addr_exc}=%b expected none (cycle %0d)",
                         {done, bus_err, addr_exc}, cyc);
            end else begin
                curEvt = evtQ.pop_front();
                check("evt_kind", 32'({done, bus_err, addr_exc}), 32'(curEvt.kind));
                check("evt_cycle", cyc, curEvt.cycle);
                if (done) begin
                    check("rdata", rdata, curEvt.rdata);
                    check("busy_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] wd,
                         input int delay, input logic [31:0] word, input bit withEvent);
        int        sz = opSize(op);
        bit        bad = (int'(a[1:0]) % sz) != 0;
        int        t;
        reqItem_t  r;
        evtItem_t  e;
        respItem_t rs;
        @(negedge clk); #2;
        t = cyc;
        evtBase = evtSeen;
        op_valid = 1'b1;
        op_type = 3'(op);
        addr = a;
        wdata = wd;
        pc = $urandom;
        if (bad) begin
            e.kind = 3'b001; e.cycle = t + 1; e.rdata = 32'd0;
            if (withEvent) evtQ.push_back(e);
        end else begin
            r.addr = {a[31:2], 2'b00};
            r.be = modelBe(op, a);
            r.we = opStore(op);
            r.wdata = modelData(op, wd);
            r.pc = pc;
            r.reqCycles = !withEvent ? -1 : (delay < MAX_WAIT ? delay + 1 : MAX_WAIT);
            reqQ.push_back(r);
            rs.delay = delay; rs.word = word;
            respQ.push_back(rs);
            if (delay < MAX_WAIT) begin
                e.kind = 3'b100; e.cycle = t + 2 + delay;
                e.rdata = opStore(op) ? 32'd0 : modelLoad(op, a, word);
            end else begin
                e.kind = 3'b010; e.cycle = t + 1 + MAX_WAIT; e.rdata = 32'd0;
            end
            if (withEvent) evtQ.push_back(e);
        end
        #1 check("busy_accept", 32'(busy), 32'(!bad));
        @(negedge clk); #2;
        op_valid = 1'b0;
    endtask

    // Wait for the op's completion, scribbling on the inputs while the request is pending.
    task automatic waitEvent();
        bit got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (evtSeen != evtBase) begin
                got = 1'b1;
                break;
            end
            if (mem_req) begin
                op_valid = 1'($urandom);
                op_type = 3'($urandom);
                addr = $urandom;
                wdata = $urandom;
                pc = $urandom;
            end
            @(negedge clk); #2;
        end
        op_valid = 1'b0;
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL event_timeout: got no completion within 64 cycles expected one (cycle %0d)", cyc);
        end
    endtask

    initial begin
        int          op;
        int          sz;
        int          r;
        int          start;
        logic [31:0] a;

        // Reset state.
        repeat (3) @(negedge clk);
        #2;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr_exc", 32'(addr_exc), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        reset = 1'b1;

        // Directed cases.
        issue(5, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'd0, 1'b1); waitEvent();
        issue(7, 32'h0000_0013, 32'h0000_00A5, 1, 32'd0, 1'b1); waitEvent();
        issue(6, 32'h0000_0012, 32'h0000_1234, 2, 32'd0, 1'b1); waitEvent();
        issue(3, 32'h0000_0002, 32'd0, 0, 32'h80FF_7F01, 1'b1); waitEvent();
        issue(4, 32'h0000_0003, 32'd0, 3, 32'h80FF_7F01, 1'b1); waitEvent();
        issue(1, 32'h0000_0002, 32'd0, 1, 32'h80FF_7F01, 1'b1); waitEvent();
        issue(2, 32'h0000_0000, 32'd0, 0, 32'h80FF_7F01, 1'b1); waitEvent();
        issue(0, 32'h0000_0006, 32'd0, 0, 32'd0, 1'b1); waitEvent();
        issue(6, 32'h0000_0005, 32'h0000_BEEF, 0, 32'd0, 1'b1); waitEvent();
        issue(0, 32'h0000_0020, 32'd0, NEVER, 32'd0, 1'b1); waitEvent();
        issue(0, 32'h0000_0024, 32'd0, 0, 32'h1357_9BDF, 1'b1); waitEvent();

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 7);
            sz = opSize(op);
            a = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = {a[31:2], 2'b00} + 32'(sz * $urandom_range(0, 4 / sz - 1));
            r = $urandom_range(0, 9);
            issue(op, a, $urandom, (r < 8) ? (r % MAX_WAIT) : NEVER, $urandom, 1'b1);
            waitEvent();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset while a request is outstanding, then a stray ack.
        issue(5, 32'h0000_0100, 32'h0000_0055, NEVER, 32'd0, 1'b0);
        @(negedge clk); #2;
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        reset = 1'b0;
        @(negedge clk); #2;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bus_err", 32'(bus_err), 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_pc", mem_pc, 32'd0);
        reset = 1'b1;
        holdAck = 1'b1;
        start = evtSeen;
        repeat (8) @(negedge clk);
        #2;
        holdAck = 1'b0;
        check("postrst_no_event", evtSeen, start);
        check("postrst_mem_req", 32'(mem_req), 32'd0);

        check("evtq_drained", evtQ.size(), 32'd0);
        check("reqq_drained", reqQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
